// File: rtl/operand_fetch_pkg.sv
// ============================================================================
// operand_fetch_pkg : shared widths, constants and output bundle type
// Rev 1.0
// ============================================================================
`default_nettype none

package operand_fetch_pkg;
  localparam int ADSize = 5;
  localparam int DASize = 32;

  localparam logic [ADSize-1:0] REG_ZERO  = '0;
  localparam logic [15:0]       STALL_MAX = 16'hFFFF;

  typedef struct packed {
    logic [DASize-1:0] op1;
    logic [DASize-1:0] op2;
    logic [ADSize-1:0] rd;
    logic              rd_we;
  } out_bundle_t;
endpackage

`default_nettype wire

// File: rtl/operand_fetch_fwd_mux.sv
// ============================================================================
// fwd_mux : per-operand bypass select (x0, EX forward, WB forward, regfile)
// Rev 1.0
// ============================================================================
`default_nettype none

module fwd_mux #(
  parameter int ADSize = operand_fetch_pkg::ADSize,
  parameter int DASize = operand_fetch_pkg::DASize
) (
  input  logic [ADSize-1:0] src,
  input  logic              ex_fwd_valid,
  input  logic [ADSize-1:0] ex_fwd_addr,
  input  logic [DASize-1:0] ex_fwd_data,
  input  logic              wb_we,
  input  logic [ADSize-1:0] wb_addr,
  input  logic [DASize-1:0] wb_data,
  input  logic [DASize-1:0] rf_data,
  output logic [DASize-1:0] data
);

  // The youngest producer wins; x0 is hardwired regardless of any forward.
  always_comb begin
    data = rf_data;
    if (src == '0) begin
      data = '0;
    end else if (ex_fwd_valid && (ex_fwd_addr == src)) begin
      data = ex_fwd_data;
    end else if (wb_we && (wb_addr == src)) begin
      data = wb_data;
    end
  end

endmodule

`default_nettype wire

// File: rtl/operand_fetch.sv
// ============================================================================
// operand_fetch : operand resolution, load-use interlock and output register
// Rev 1.0
// ============================================================================
`default_nettype none

module operand_fetch #(
  parameter int ADSize = operand_fetch_pkg::ADSize,
  parameter int DASize = operand_fetch_pkg::DASize
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADSize-1:0] in_rs1,
  input  logic [ADSize-1:0] in_rs2,
  input  logic [ADSize-1:0] in_rd,
  input  logic              in_rs1_used,
  input  logic              in_rs2_used,
  input  logic              in_rd_we,
  output logic [ADSize-1:0] rf_addr_1,
  output logic [ADSize-1:0] rf_addr_2,
  input  logic [DASize-1:0] rf_data_1,
  input  logic [DASize-1:0] rf_data_2,
  input  logic              ex_fwd_valid,
  input  logic              ex_load_pending,
  input  logic [ADSize-1:0] ex_fwd_addr,
  input  logic [DASize-1:0] ex_fwd_data,
  input  logic              wb_we,
  input  logic [ADSize-1:0] wb_addr,
  input  logic [DASize-1:0] wb_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DASize-1:0] out_op1,
  output logic [DASize-1:0] out_op2,
  output logic [ADSize-1:0] out_rd,
  output logic              out_rd_we,
  output logic [15:0]       stall_cnt
);

  import operand_fetch_pkg::*;

  logic [DASize-1:0] op1;
  logic [DASize-1:0] op2;
  logic              hazard;
  logic              capture;

  out_bundle_t       out_q, out_d;
  logic              out_valid_q, out_valid_d;
  logic [15:0]       stall_cnt_q, stall_cnt_d;

  assign rf_addr_1 = in_rs1;
  assign rf_addr_2 = in_rs2;

  fwd_mux #(.ADSize(ADSize), .DASize(DASize)) u_fwd_1 (
    .src(in_rs1), .ex_fwd_valid(ex_fwd_valid), .ex_fwd_addr(ex_fwd_addr),
    .ex_fwd_data(ex_fwd_data), .wb_we(wb_we), .wb_addr(wb_addr),
    .wb_data(wb_data), .rf_data(rf_data_1), .data(op1)
  );

  fwd_mux #(.ADSize(ADSize), .DASize(DASize)) u_fwd_2 (
    .src(in_rs2), .ex_fwd_valid(ex_fwd_valid), .ex_fwd_addr(ex_fwd_addr),
    .ex_fwd_data(ex_fwd_data), .wb_we(wb_we), .wb_addr(wb_addr),
    .wb_data(wb_data), .rf_data(rf_data_2), .data(op2)
  );

  always_comb begin
    hazard = ex_load_pending && (ex_fwd_addr != REG_ZERO) &&
             ((in_rs1_used && (ex_fwd_addr == in_rs1)) ||
              (in_rs2_used && (ex_fwd_addr == in_rs2)));
    // A flushed instruction is always swallowed, so flush forces ready.
    in_ready    = flush || (!hazard && (!out_valid_q || out_ready));
    capture     = in_valid && in_ready && !flush;

    out_d       = out_q;
    out_valid_d = out_valid_q;
    stall_cnt_d = stall_cnt_q;

    if (flush) begin
      out_valid_d = 1'b0;
    end else if (capture) begin
      out_valid_d  = 1'b1;
      out_d.op1    = op1;
      out_d.op2    = op2;
      out_d.rd     = in_rd;
      out_d.rd_we  = in_rd_we && (in_rd != REG_ZERO);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    if (in_valid && hazard && !flush && (stall_cnt_q != STALL_MAX)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_op1   = out_q.op1;
  assign out_op2   = out_q.op2;
  assign out_rd    = out_q.rd;
  assign out_rd_we = out_q.rd_we;
  assign stall_cnt = stall_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_operand_fetch.sv
// ============================================================================
// tb_operand_fetch : directed scenarios plus randomized model comparison
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_operand_fetch;
  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready;
  logic [AW-1:0] in_rs1, in_rs2, in_rd;
  logic          in_rs1_used, in_rs2_used, in_rd_we;
  logic [AW-1:0] rf_addr_1, rf_addr_2;
  logic [DW-1:0] rf_data_1, rf_data_2;
  logic          ex_fwd_valid, ex_load_pending;
  logic [AW-1:0] ex_fwd_addr;
  logic [DW-1:0] ex_fwd_data;
  logic          wb_we;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic          flush, out_valid, out_ready, out_rd_we;
  logic [DW-1:0] out_op1, out_op2;
  logic [AW-1:0] out_rd;
  logic [15:0]   stall_cnt;

  int total = 0;
  int bad   = 0;
  int exp_cnt = 0;

  operand_fetch #(.ADSize(AW), .DASize(DW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_rs1_used(in_rs1_used), .in_rs2_used(in_rs2_used), .in_rd_we(in_rd_we),
    .rf_addr_1(rf_addr_1), .rf_addr_2(rf_addr_2),
    .rf_data_1(rf_data_1), .rf_data_2(rf_data_2),
    .ex_fwd_valid(ex_fwd_valid), .ex_load_pending(ex_load_pending),
    .ex_fwd_addr(ex_fwd_addr), .ex_fwd_data(ex_fwd_data),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_op1(out_op1), .out_op2(out_op2), .out_rd(out_rd),
    .out_rd_we(out_rd_we), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Reference operand selection straight from the bypass priority rules.
  function automatic logic [DW-1:0] ref_operand(input logic [AW-1:0] src);
    if (src == 0)                                return '0;
    if (ex_fwd_valid && ex_fwd_addr == src)      return ex_fwd_data;
    if (wb_we && wb_addr == src)                 return wb_data;
    return (src == in_rs1) ? rf_data_1 : rf_data_2;
  endfunction

  task automatic idle_inputs();
    in_valid = 0; in_rs1 = 0; in_rs2 = 0; in_rd = 0;
    in_rs1_used = 0; in_rs2_used = 0; in_rd_we = 0;
    rf_data_1 = 0; rf_data_2 = 0;
    ex_fwd_valid = 0; ex_load_pending = 0; ex_fwd_addr = 0; ex_fwd_data = 0;
    wb_we = 0; wb_addr = 0; wb_data = 0; flush = 0; out_ready = 1;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 0;
    #3;
    total++; if ({out_valid, out_op1, out_op2, out_rd, out_rd_we, stall_cnt} !== '0) begin
      bad++; $display("FAIL reset_state: got v=%0b op1=%h op2=%h rd=%0d we=%0b cnt=%0d, want all 0",
                      out_valid, out_op1, out_op2, out_rd, out_rd_we, stall_cnt); end
    @(negedge clk); rst = 1;
    tick();
    exp_cnt = 0;
  endtask

  task automatic test_regfile();
    in_valid = 1; in_rs1 = 3; in_rs2 = 4; in_rs1_used = 1; in_rs2_used = 1;
    rf_data_1 = 32'h11; rf_data_2 = 32'h22; in_rd = 6; in_rd_we = 1;
    #1;
    total++; if (rf_addr_1 !== 5'd3 || rf_addr_2 !== 5'd4) begin
      bad++; $display("FAIL rf_addr: got %0d/%0d, want 3/4", rf_addr_1, rf_addr_2); end
    tick();
    total++; if (out_valid !== 1 || out_op1 !== 32'h11 || out_op2 !== 32'h22 || out_rd !== 6 || out_rd_we !== 1) begin
      bad++; $display("FAIL regfile_read: got v=%0b op1=%h op2=%h rd=%0d we=%0b, want 1/11/22/6/1",
                      out_valid, out_op1, out_op2, out_rd, out_rd_we); end
    in_valid = 0;
    tick();
    total++; if (out_valid !== 0) begin
      bad++; $display("FAIL drain: out_valid=%0b, want 0", out_valid); end
  endtask

  task automatic test_double_match();
    in_valid = 1; in_rs1 = 5; in_rs2 = 5; in_rs1_used = 1; in_rs2_used = 1;
    rf_data_1 = 32'h1234; rf_data_2 = 32'h5678;
    ex_fwd_valid = 1; ex_fwd_addr = 5; ex_fwd_data = 32'hAA;
    wb_we = 1; wb_addr = 5; wb_data = 32'hBB;
    tick();
    total++; if (out_op1 !== 32'hAA || out_op2 !== 32'hAA) begin
      bad++; $display("FAIL ex_priority: got %h/%h, want aa/aa", out_op1, out_op2); end
    ex_fwd_valid = 0;
    tick();
    total++; if (out_op1 !== 32'hBB || out_op2 !== 32'hBB || out_valid !== 1) begin
      bad++; $display("FAIL wb_forward: got %h/%h v=%0b, want bb/bb v=1", out_op1, out_op2, out_valid); end
    idle_inputs();
  endtask

  task automatic test_load_use();
    in_valid = 1; in_rs1 = 1; in_rs2 = 7; in_rs1_used = 1; in_rs2_used = 1;
    rf_data_1 = 32'h10; rf_data_2 = 32'h20;
    ex_load_pending = 1; ex_fwd_addr = 7;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (in_ready !== 0) begin
        bad++; $display("FAIL load_use_ready cycle %0d: in_ready=%0b, want 0", i, in_ready); end
      tick();
      exp_cnt++;
    end
    total++; if (stall_cnt !== 16'(exp_cnt) || out_valid !== 0) begin
      bad++; $display("FAIL load_use_stall: cnt=%0d v=%0b, want cnt=%0d v=0", stall_cnt, out_valid, exp_cnt); end
    ex_load_pending = 0; ex_fwd_valid = 1; ex_fwd_data = 32'h77;
    #1;
    total++; if (in_ready !== 1) begin
      bad++; $display("FAIL load_done_ready: in_ready=%0b, want 1", in_ready); end
    tick();
    total++; if (out_valid !== 1 || out_op2 !== 32'h77 || out_op1 !== 32'h10) begin
      bad++; $display("FAIL load_use_capture: v=%0b op1=%h op2=%h, want 1/10/77", out_valid, out_op1, out_op2); end
    // Same dependency, but rs2 is not read: no interlock.
    ex_fwd_valid = 0; ex_load_pending = 1; in_rs2_used = 0; rf_data_1 = 32'h31;
    #1;
    total++; if (in_ready !== 1) begin
      bad++; $display("FAIL unused_ready: in_ready=%0b, want 1", in_ready); end
    tick();
    total++; if (stall_cnt !== 16'(exp_cnt) || out_valid !== 1 || out_op1 !== 32'h31) begin
      bad++; $display("FAIL unused_no_stall: cnt=%0d v=%0b op1=%h, want cnt=%0d v=1 op1=31",
                      stall_cnt, out_valid, out_op1, exp_cnt); end
    idle_inputs();
  endtask

  task automatic test_x0();
    in_valid = 1; in_rs1 = 0; in_rs2 = 2; in_rs1_used = 1; in_rs2_used = 1;
    rf_data_1 = 32'hDEAD; rf_data_2 = 32'h42;
    ex_fwd_valid = 1; ex_fwd_addr = 0; ex_fwd_data = 32'hFFFF_FFFF;
    in_rd = 0; in_rd_we = 1;
    tick();
    total++; if (out_op1 !== 0 || out_op2 !== 32'h42 || out_rd !== 0 || out_rd_we !== 0) begin
      bad++; $display("FAIL x0: op1=%h op2=%h rd=%0d we=%0b, want 0/42/0/0", out_op1, out_op2, out_rd, out_rd_we); end
    in_rd = 9;
    tick();
    total++; if (out_rd !== 9 || out_rd_we !== 1) begin
      bad++; $display("FAIL rd_we_nonzero: rd=%0d we=%0b, want 9/1", out_rd, out_rd_we); end
    idle_inputs();
  endtask

  task automatic test_backpressure_flush();
    in_valid = 1; in_rs1 = 3; in_rs2 = 4; in_rs1_used = 1;
    rf_data_1 = 32'h55; rf_data_2 = 32'h66; in_rd = 4; in_rd_we = 1;
    tick();
    out_ready = 0; rf_data_1 = 32'h99; rf_data_2 = 32'h88; in_rd = 8;
    for (int i = 0; i < 2; i++) begin
      #1;
      total++; if (in_ready !== 0) begin
        bad++; $display("FAIL bp_ready cycle %0d: in_ready=%0b, want 0", i, in_ready); end
      tick();
      total++; if (out_valid !== 1 || out_op1 !== 32'h55 || out_op2 !== 32'h66 || out_rd !== 4 || out_rd_we !== 1) begin
        bad++; $display("FAIL bp_hold cycle %0d: v=%0b op1=%h op2=%h rd=%0d, want 1/55/66/4", i, out_valid, out_op1, out_op2, out_rd); end
    end
    flush = 1;
    #1;
    total++; if (in_ready !== 1) begin
      bad++; $display("FAIL flush_ready: in_ready=%0b, want 1", in_ready); end
    tick();
    total++; if (out_valid !== 0) begin
      bad++; $display("FAIL flush_clear: out_valid=%0b, want 0", out_valid); end
    idle_inputs();
    tick();
    total++; if (out_valid !== 0) begin
      bad++; $display("FAIL flush_discard: out_valid=%0b, want 0", out_valid); end
  endtask

  task automatic test_flush_hazard();
    in_valid = 1; in_rs1 = 6; in_rs1_used = 1; ex_load_pending = 1; ex_fwd_addr = 6; flush = 1;
    tick();
    total++; if (stall_cnt !== 16'(exp_cnt) || out_valid !== 0) begin
      bad++; $display("FAIL flush_beats_hazard: cnt=%0d v=%0b, want cnt=%0d v=0", stall_cnt, out_valid, exp_cnt); end
    idle_inputs();
  endtask

  task automatic test_reset_mid_stall();
    int guard;
    in_valid = 1; in_rs1 = 2; in_rs1_used = 1; rf_data_1 = 32'h5A; in_rd = 3; in_rd_we = 1;
    tick();
    out_ready = 0; ex_load_pending = 1; ex_fwd_addr = 2;
    guard = 0;
    while (exp_cnt < 5 && guard < 20) begin
      tick(); exp_cnt++; guard++;
    end
    total++; if (stall_cnt !== 16'd5 || out_valid !== 1 || exp_cnt != 5) begin
      bad++; $display("FAIL pre_reset_stall: cnt=%0d v=%0b, want cnt=5 v=1", stall_cnt, out_valid); end
    rst = 0;
    #1;
    total++; if ({out_valid, out_op1, out_op2, out_rd, out_rd_we, stall_cnt} !== '0) begin
      bad++; $display("FAIL async_reset: v=%0b op1=%h rd=%0d we=%0b cnt=%0d, want all 0",
                      out_valid, out_op1, out_rd, out_rd_we, stall_cnt); end
    #1; rst = 1;
    ex_load_pending = 0; out_ready = 1; rf_data_1 = 32'h3C;
    tick();
    exp_cnt = 0;
    total++; if (out_valid !== 1 || out_op1 !== 32'h3C || stall_cnt !== 0) begin
      bad++; $display("FAIL post_reset_capture: v=%0b op1=%h cnt=%0d, want 1/3c/0", out_valid, out_op1, stall_cnt); end
    idle_inputs();
  endtask

  task automatic test_random();
    logic          ev, erdwe, mhaz, mready;
    logic [DW-1:0] eop1, eop2;
    logic [AW-1:0] erd;
    int            ecnt;
    idle_inputs();
    rst = 0; #2; rst = 1;
    tick();
    ev = 0; erdwe = 0; eop1 = 0; eop2 = 0; erd = 0; ecnt = 0;
    for (int n = 0; n < 300; n++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_rs1 = AW'($urandom_range(0, 7)); in_rs2 = AW'($urandom_range(0, 7));
      in_rd = AW'($urandom_range(0, 7)); in_rd_we = 1'($urandom_range(0, 1));
      in_rs1_used = 1'($urandom_range(0, 1)); in_rs2_used = 1'($urandom_range(0, 1));
      rf_data_1 = $urandom; rf_data_2 = $urandom;
      ex_fwd_valid = 1'($urandom_range(0, 1)); ex_load_pending = ($urandom_range(0, 3) == 0);
      ex_fwd_addr = AW'($urandom_range(0, 7)); ex_fwd_data = $urandom;
      wb_we = 1'($urandom_range(0, 1)); wb_addr = AW'($urandom_range(0, 7)); wb_data = $urandom;
      flush = ($urandom_range(0, 9) == 0); out_ready = ($urandom_range(0, 3) != 0);
      #1;
      mhaz = ex_load_pending && ex_fwd_addr != 0 &&
             ((in_rs1_used && ex_fwd_addr == in_rs1) || (in_rs2_used && ex_fwd_addr == in_rs2));
      mready = flush || (!mhaz && (!ev || out_ready));
      total++; if (in_ready !== mready) begin
        bad++; $display("FAIL rand_ready n=%0d: got %0b, want %0b", n, in_ready, mready); end
      if (in_valid && mhaz && !flush && ecnt < 16'hFFFF) ecnt++;
      if (flush) ev = 0;
      else if (in_valid && mready) begin
        ev = 1;
        // rs1==rs2 picks rf_data_1 in ref_operand, so resolve each source against its own port.
        eop1 = ref_operand(in_rs1);
        eop2 = (in_rs2 == 0) ? '0 : (ex_fwd_valid && ex_fwd_addr == in_rs2) ? ex_fwd_data :
               (wb_we && wb_addr == in_rs2) ? wb_data : rf_data_2;
        erd = in_rd; erdwe = in_rd_we && (in_rd != 0);
      end else if (out_ready) ev = 0;
      tick();
      total++; if (out_valid !== ev || stall_cnt !== 16'(ecnt) ||
                   (ev && {out_op1, out_op2, out_rd, out_rd_we} !== {eop1, eop2, erd, erdwe})) begin
        bad++; $display("FAIL rand_out n=%0d: v=%0b op1=%h op2=%h rd=%0d we=%0b cnt=%0d, want v=%0b op1=%h op2=%h rd=%0d we=%0b cnt=%0d",
                        n, out_valid, out_op1, out_op2, out_rd, out_rd_we, stall_cnt, ev, eop1, eop2, erd, erdwe, ecnt); end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_regfile();
    test_double_match();
    test_load_use();
    test_x0();
    test_backpressure_flush();
    test_flush_hazard();
    test_reset_mid_stall();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
